// File: rtl/pc_fetch_unit.sv
// Fetch-PC holder with a single-outstanding instruction fetch and a valid/ready offer to decode.
// Optional same-cycle response bypass to decode is enabled by defining FETCH_BYPASS_EN.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] pc_out,
   input  logic [31:0] npc_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        align_err
);

   typedef enum logic [1:0] {RST, REQ, HOLD, DROP} state_t;

   state_t      state, state_next;
   logic [31:0] pc_q, addr_q, inst_q;
   logic        align_q;
   logic        capture, fire, load;
   logic [31:0] load_raw;

   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      imem_addr   = pc_q;
      instr_valid = 1'b0;
      instr       = inst_q;
      capture     = 1'b0;
      case (state)
         RST: state_next = REQ;
         REQ: begin
            imem_req = 1'b1;
            if (imem_rvalid) begin
               if (flush) begin
                  state_next = REQ;
               end else begin
                  capture    = 1'b1;
                  state_next = HOLD;
`ifdef FETCH_BYPASS_EN
                  instr_valid = 1'b1;
                  instr       = imem_rdata;
                  if (instr_ready) begin
                     capture    = 1'b0;
                     state_next = REQ;
                  end
`endif
               end
            end else if (flush) begin
               state_next = DROP;
            end
         end
         HOLD: begin
            // A redirect masks the offer so npc_in is never loaded in a flush cycle.
            instr_valid = !flush;
            if (flush || instr_ready) state_next = REQ;
         end
         DROP: begin
            // The old request must stay stable until its (discarded) response returns.
            imem_req  = 1'b1;
            imem_addr = addr_q;
            if (imem_rvalid) state_next = REQ;
         end
         default: state_next = RST;
      endcase
   end

   assign fire     = instr_valid && instr_ready;
   assign load     = flush || fire;
   assign load_raw = flush ? flush_pc : npc_in;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= RST;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         inst_q  <= 32'h0;
         align_q <= 1'b0;
      end else begin
         state   <= state_next;
         align_q <= load && (load_raw[1:0] != 2'b00);
         if (load) pc_q <= {load_raw[31:2], 2'b00};
         if (state == REQ) addr_q <= pc_q;
         if (capture) inst_q <= imem_rdata;
      end
   end

   assign pc_out    = pc_q;
   assign instr_pc  = pc_q;
   assign align_err = align_q;

endmodule
